// File: rtl/idli_nibble_ser_m.sv
// Serializes 16-bit decode words into four MSB-first nibbles with a one-entry
// pending buffer so that back-to-back words stream without bubbles.
module idli_nibble_ser_m (
    input  logic        i_dcd_gck,
    input  logic        i_dcd_rst_n,
    input  logic [15:0] i_dcd_word,
    input  logic        i_dcd_word_vld,
    output logic        o_dcd_word_rdy,
    input  logic        i_dcd_hold,
    input  logic        i_dcd_flush,
    output logic [3:0]  o_dcd_enc,
    output logic        o_dcd_enc_vld,
    output logic [1:0]  o_dcd_cycle,
    output logic        o_dcd_idle
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [15:0] cur_r;
    logic [15:0] cur_nxt_s;
    logic [1:0]  cnt_r;
    logic [1:0]  cnt_nxt_s;
    logic [15:0] pend_r;
    logic [15:0] pend_nxt_s;
    logic        pend_vld_r;
    logic        pend_vld_nxt_s;

    logic        busy_s;
    logic        boundary_s;
    logic        accept_s;
    logic        start_s;
    logic [15:0] load_s;

    assign busy_s     = (state_r == ST_BUSY);
    assign boundary_s = !busy_s || (cnt_r == 2'd3);
    assign accept_s   = i_dcd_word_vld && !pend_vld_r && !i_dcd_flush;
    // A pending word always has priority over the word on the input bus.
    assign start_s    = boundary_s && !i_dcd_hold && !i_dcd_flush && (pend_vld_r || accept_s);
    assign load_s     = pend_vld_r ? pend_r : i_dcd_word;

    // State register and datapath flops.
    always_ff @(posedge i_dcd_gck or negedge i_dcd_rst_n) begin
        if (!i_dcd_rst_n) begin
            state_r    <= ST_IDLE;
            cur_r      <= 16'h0000;
            cnt_r      <= 2'd0;
            pend_r     <= 16'h0000;
            pend_vld_r <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            cur_r      <= cur_nxt_s;
            cnt_r      <= cnt_nxt_s;
            pend_r     <= pend_nxt_s;
            pend_vld_r <= pend_vld_nxt_s;
        end
    end

    // Next-state logic for the shifter and its nibble counter.
    always_comb begin
        next_state_s = state_r;
        cur_nxt_s    = cur_r;
        cnt_nxt_s    = cnt_r;
        case (state_r)
            ST_BUSY: begin
                if (cnt_r != 2'd3) begin
                    cur_nxt_s = {cur_r[11:0], 4'h0};
                    cnt_nxt_s = cnt_r + 2'd1;
                end else if (start_s) begin
                    cur_nxt_s = load_s;
                    cnt_nxt_s = 2'd0;
                end else begin
                    // Shift the last nibble out so the idle bus reads zero.
                    cur_nxt_s    = {cur_r[11:0], 4'h0};
                    cnt_nxt_s    = 2'd0;
                    next_state_s = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (start_s) begin
                    cur_nxt_s    = load_s;
                    cnt_nxt_s    = 2'd0;
                    next_state_s = ST_BUSY;
                end else begin
                    cnt_nxt_s = 2'd0;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                cur_nxt_s    = 16'h0000;
                cnt_nxt_s    = 2'd0;
            end
        endcase
    end

    // Pending-buffer control: flush wins, then drain on start, then capture.
    always_comb begin
        pend_nxt_s     = pend_r;
        pend_vld_nxt_s = pend_vld_r;
        if (i_dcd_flush) begin
            pend_vld_nxt_s = 1'b0;
        end else if (start_s && pend_vld_r) begin
            pend_vld_nxt_s = 1'b0;
        end else if (accept_s && !start_s) begin
            pend_nxt_s     = i_dcd_word;
            pend_vld_nxt_s = 1'b1;
        end else begin
            pend_vld_nxt_s = pend_vld_r;
        end
    end

    assign o_dcd_enc      = cur_r[15:12];
    assign o_dcd_enc_vld  = busy_s;
    assign o_dcd_cycle    = cnt_r;
    assign o_dcd_word_rdy = !pend_vld_r;
    assign o_dcd_idle     = !busy_s && !pend_vld_r;

endmodule
